// File: rtl/window_sad_matcher.sv
// Window SAD matcher: captures 16x16 windows, accumulates SAD vs. a template one row per
// cycle and tracks the frame minimum. Optional macro SAD_EARLY_ABORT_EN stops hopeless windows early.
module window_sad_matcher #(
    parameter int PIX_W = 8,
    parameter int IDX_W = 16,
    parameter int SAD_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [15:0][15:0][PIX_W-1:0]     template_data,
    input  logic [15:0][15:0][PIX_W-1:0]     window_data,
    input  logic                             window_ready,
    input  logic                             frame_done,
    output logic                             receive,
    output logic                             busy,
    output logic [SAD_W-1:0]                 best_sad,
    output logic [IDX_W-1:0]                 best_index,
    output logic                             result_valid,
    output logic                             overrun
);

    // state   | meaning
    // IDLE    | waiting for a window; reports a pending frame result
    // ACCUM   | accumulating one row of |window - template| per cycle
    // COMPARE | folding the finished SAD into the frame minimum
    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE} state_t;

    localparam int ROW_W = PIX_W + 4;

    state_t                         state, state_nx;
    logic [15:0][15:0][PIX_W-1:0]   win_buf;
    logic [3:0]                     row;
    logic [SAD_W-1:0]               acc, acc_sum;
    logic [ROW_W-1:0]               row_sum;
    logic [IDX_W-1:0]               win_cnt, cur_idx;
    logic                           armed, done_pend;
    logic                           accept, drop, abort;

    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        row_sum = '0;
        for (int c = 0; c < 16; c++)
            row_sum = row_sum + ROW_W'(absdiff(win_buf[row][c], template_data[row][c]));
        acc_sum = acc + SAD_W'(row_sum);
    end

    // A pending frame result blocks new captures: that frame is about to close.
    assign accept       = armed && window_ready && !start && (state == IDLE) && !done_pend;
    assign drop         = armed && window_ready && !start && (state != IDLE);
    assign receive      = accept;
    assign busy         = (state != IDLE);
    assign result_valid = (state == IDLE) && done_pend;

`ifdef SAD_EARLY_ABORT_EN
    assign abort = (state == ACCUM) && (acc_sum >= best_sad);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACCUM;
            ACCUM: begin
                if (abort)            state_nx = IDLE;
                else if (row == 4'd15) state_nx = COMPARE;
            end
            COMPARE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (start) state_nx = IDLE;
    end

    always_ff @(posedge clk)
        if (accept) win_buf <= window_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            done_pend  <= 1'b0;
            overrun    <= 1'b0;
            best_sad   <= '1;
            best_index <= '0;
            win_cnt    <= '0;
            cur_idx    <= '0;
            acc        <= '0;
            row        <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                armed      <= 1'b1;
                done_pend  <= 1'b0;
                overrun    <= 1'b0;
                best_sad   <= '1;
                best_index <= '0;
                win_cnt    <= '0;
                acc        <= '0;
                row        <= '0;
            end else begin
                if (accept) begin
                    cur_idx <= win_cnt;
                    acc     <= '0;
                    row     <= '0;
                end
                if (accept || drop) win_cnt <= win_cnt + IDX_W'(1);
                if (drop) overrun <= 1'b1;
                if (frame_done) begin
                    done_pend <= 1'b1;
                end else if (result_valid) begin
                    done_pend <= 1'b0;
                    armed     <= 1'b0;
                end
                case (state)
                    ACCUM: begin
                        acc <= abort ? '0 : acc_sum;
                        row <= row + 4'd1;
                    end
                    COMPARE: begin
                        if (acc < best_sad) begin
                            best_sad   <= acc;
                            best_index <= cur_idx;
                        end
                        acc <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_sad_matcher.sv
// Directed self-checking bench for window_sad_matcher with hand-computed SAD values.
module tb_window_sad_matcher;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [15:0][15:0][7:0]   tmpl = '0;
    logic [15:0][15:0][7:0]   win = '0;
    logic                     window_ready = 1'b0;
    logic                     frame_done = 1'b0;
    logic                     receive, busy, result_valid, overrun;
    logic [15:0]              best_sad, best_index;

    int errors = 0;
    int checks = 0;

    window_sad_matcher #(.PIX_W(8), .IDX_W(16), .SAD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .template_data(tmpl),
        .window_data(win), .window_ready(window_ready), .frame_done(frame_done),
        .receive(receive), .busy(busy), .best_sad(best_sad), .best_index(best_index),
        .result_valid(result_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic fill(input logic [7:0] t, input logic [7:0] w);
        tmpl = {256{t}};
        win  = {256{w}};
    endtask

    // Presents a window for one cycle and checks the same-cycle acknowledge.
    task automatic send(input string tag, input logic [7:0] w, input logic exp_rx);
        win = {256{w}};
        window_ready = 1'b1;
        #1;
        chk(tag, 32'(receive), 32'(exp_rx));
        cyc();
        window_ready = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_receive", 32'(receive), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_best_sad", 32'(best_sad), 32'hFFFF);
        chk("rst_best_index", 32'(best_index), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Window before any start is ignored.
        fill(8'h40, 8'h40);
        send("unarmed_receive", 8'h40, 1'b0);
        chk("unarmed_busy", 32'(busy), 32'd0);

        // Identical patches -> SAD 0.
        do_start();
        send("t1_receive", 8'h40, 1'b1);
        chk("t1_busy_T1", 32'(busy), 32'd1);
        cyc(16);
        chk("t1_busy_T17", 32'(busy), 32'd1);
        chk("t1_sad_T17", 32'(best_sad), 32'hFFFF);
        cyc();
        chk("t1_busy_T18", 32'(busy), 32'd0);
        chk("t1_sad", 32'(best_sad), 32'd0);
        chk("t1_index", 32'(best_index), 32'd0);
        frame_done = 1'b1;
        #1;
        chk("t1_rv_early", 32'(result_valid), 32'd0);
        cyc();
        frame_done = 1'b0;
        chk("t1_rv_pulse", 32'(result_valid), 32'd1);
        cyc();
        chk("t1_rv_end", 32'(result_valid), 32'd0);

        // Template 0, windows 01/03/02 -> 256/768/512; best stays 256 at index 0.
        fill(8'h00, 8'h00);
        do_start();
        chk("t2_start_sad", 32'(best_sad), 32'hFFFF);
        send("t2_rx0", 8'h01, 1'b1);
        cyc(17);
        chk("t2_sad_w0", 32'(best_sad), 32'd256);
        cyc(2);
        send("t2_rx1", 8'h03, 1'b1);
        cyc(17);
        chk("t2_sad_w1", 32'(best_sad), 32'd256);
        cyc(2);
        send("t2_rx2", 8'h02, 1'b1);
        cyc(17);
        chk("t2_sad_w2", 32'(best_sad), 32'd256);
        chk("t2_index", 32'(best_index), 32'd0);
        chk("t2_overrun", 32'(overrun), 32'd0);

        // Overrun: second window 5 cycles after first is dropped but counted.
        do_start();
        send("t3_rx0", 8'h05, 1'b1);
        cyc(4);
        send("t3_rx_drop", 8'h01, 1'b0);
        chk("t3_overrun", 32'(overrun), 32'd1);
        cyc(19);
        send("t3_rx2", 8'h02, 1'b1);
        cyc(17);
        chk("t3_sad", 32'(best_sad), 32'd512);
        chk("t3_index", 32'(best_index), 32'd2);
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);
        do_start();
        chk("t3_overrun_cleared", 32'(overrun), 32'd0);

        // Full-scale tie: 65280 twice, first index kept.
        send("t4_rx0", 8'hFF, 1'b1);
        cyc(19);
        send("t4_rx1", 8'hFF, 1'b1);
        cyc(17);
        chk("t4_sad", 32'(best_sad), 32'd65280);
        chk("t4_index", 32'(best_index), 32'd0);

        // frame_done during ACCUM waits for the in-flight window, then disarms.
        do_start();
        send("t5_rx", 8'h07, 1'b1);
        cyc(2);
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        cyc(13);
        chk("t5_rv_T17", 32'(result_valid), 32'd0);
        cyc();
        chk("t5_rv_T18", 32'(result_valid), 32'd1);
        chk("t5_sad", 32'(best_sad), 32'd1792);
        cyc();
        chk("t5_rv_T19", 32'(result_valid), 32'd0);
        send("t5_rx_after", 8'h00, 1'b0);
        chk("t5_busy_after", 32'(busy), 32'd0);

        // Asynchronous reset mid-ACCUM.
        do_start();
        send("t6_rx0", 8'h01, 1'b1);
        cyc(19);
        chk("t6_sad_pre", 32'(best_sad), 32'd256);
        send("t6_rx1", 8'h03, 1'b1);
        cyc(4);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_sad_rst", 32'(best_sad), 32'hFFFF);
        chk("t6_idx_rst", 32'(best_index), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

`ifdef SAD_EARLY_ABORT_EN
        // best=0 makes the next window abort after its first row.
        do_start();
        send("ea_rx0", 8'h00, 1'b1);
        cyc(19);
        chk("ea_sad0", 32'(best_sad), 32'd0);
        send("ea_rx1", 8'h01, 1'b1);
        chk("ea_busy_T1", 32'(busy), 32'd1);
        cyc();
        chk("ea_busy_T2", 32'(busy), 32'd0);
        chk("ea_sad_kept", 32'(best_sad), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
